fetch_unit: RTL and testbench

In-order instruction fetch stage that sits directly upstream of the instruction FIFO. It holds the architectural fetch PC and issues one word request at a time to instruction memory. It packs each returned instruction with its PC and enqueues the pair into the FIFO through a valid/ready handshake. Backend redirects (branch mispredict, exception) re-steer the PC and discard any in-flight or held fetch.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc_gen.sv | 48 ++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types: state enum, widths, FIFO entry struct
package fetch_pkg;

   localparam int XLEN              = 32;
   localparam int INSTR_WIDTH       = XLEN;
   localparam int FETCH_ENTRY_WIDTH = 2 * XLEN;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

   // Layout shared with the downstream instruction FIFO: pc in the upper half.
   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic [INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC register and next-PC mux (optional FETCH_INIT_EN preload port)
module fetch_pc_gen #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  logic            clk,
   input  logic            rst_aH,
`ifdef FETCH_INIT_EN
   input  logic            init_i,
   input  logic [XLEN-1:0] init_pc_i,
`endif
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            advance_i,
   output logic [XLEN-1:0] pc_o
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // Next-PC priority: init, then redirect, then sequential advance, else hold.
   // Low two bits are always cleared so the fetch address stays word aligned.
   always_comb begin
      pc_d = pc_q;
`ifdef FETCH_INIT_EN
      if (init_i) begin
         pc_d = {init_pc_i[XLEN-1:2], 2'b00};
      end else
`endif
      if (redirect_i) begin
         pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      end else if (advance_i) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   // PC register; the add above wraps modulo 2^XLEN.
   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order fetch stage feeding the instruction FIFO (optional FETCH_INIT_EN)
module fetch_unit #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              ENTRY_WIDTH = 2 * XLEN
)(
   input  logic                   clk,
   input  logic                   rst_aH,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [XLEN-1:0]        imem_req_addr,
   input  logic                   imem_resp_valid,
   input  logic [XLEN-1:0]        imem_resp_data,
   input  logic                   redirect_valid,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic                   enq_valid,
   input  logic                   enq_ready,
   output logic [ENTRY_WIDTH-1:0] enq_data
`ifdef FETCH_INIT_EN
   ,
   input  logic                   init,
   input  logic [XLEN-1:0]        init_pc
`endif
);

   import fetch_pkg::*;

   fetch_state_t    state_q;
   logic [XLEN-1:0] hold_instr_q;
   logic [XLEN-1:0] pc;
   logic            fresh_q;
   logic            req_fire;
   logic            enq_fire;

   // Request is suppressed while reset is held even though state already reads REQ.
   assign imem_req_valid = (state_q == REQ) && !rst_aH;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Redirect beats the enqueue: enq_valid never depends on enq_ready.
   assign enq_valid = (state_q == HOLD) && !redirect_valid;
   assign enq_fire  = enq_valid && enq_ready;
   assign enq_data  = (state_q == HOLD) ? {pc, hold_instr_q} : '0;

   fetch_pc_gen #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk           (clk),
      .rst_aH        (rst_aH),
`ifdef FETCH_INIT_EN
      .init_i        (init),
      .init_pc_i     (init_pc),
`endif
      .redirect_i    (redirect_valid),
      .redirect_pc_i (redirect_pc),
      .advance_i     (enq_fire),
      .pc_o          (pc)
   );

   // Fetch FSM: one outstanding request, redirect discards in-flight or held work.
   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         state_q      <= REQ;
         hold_instr_q <= '0;
         fresh_q      <= 1'b1;
      end
`ifdef FETCH_INIT_EN
      else if (init) begin
         state_q      <= REQ;
         hold_instr_q <= '0;
      end
`endif
      else begin
         if (req_fire) begin
            fresh_q <= 1'b0;
         end
         case (state_q)
            REQ: begin
               if (req_fire) begin
                  state_q <= redirect_valid ? DRAIN : WAIT;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  state_q <= imem_resp_valid ? REQ : DRAIN;
               end else if (imem_resp_valid) begin
                  hold_instr_q <= imem_resp_data;
                  state_q      <= HOLD;
               end
            end
            HOLD: begin
               if (redirect_valid || enq_ready) begin
                  state_q <= REQ;
               end
            end
            DRAIN: begin
               if (imem_resp_valid) begin
                  state_q <= REQ;
               end
            end
            default: state_q <= REQ;
         endcase
      end
   end

   // A response is illegal in HOLD, and in REQ unless it may be the stale
   // answer to a request that was in flight when reset hit (fresh_q).
   a_resp_protocol: assert property (@(posedge clk) disable iff (rst_aH)
      !(imem_resp_valid && ((state_q == HOLD) || ((state_q == REQ) && !fresh_q))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (FETCH_INIT_EN adds init-preload vectors)
module tb_fetch_unit;

   logic        clk;
   logic        rst_aH;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        enq_valid;
   logic        enq_ready;
   logic [63:0] enq_data;
`ifdef FETCH_INIT_EN
   logic        init;
   logic [31:0] init_pc;
`endif

   logic        auto_mem;
   logic        auto_v;
   logic [31:0] auto_d;
   logic        man_v;
   logic [31:0] man_d;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] exp_req[$];
   logic [63:0] exp_enq[$];
   int          enq_cyc[$];

   assign imem_resp_valid = auto_v | man_v;
   assign imem_resp_data  = auto_v ? auto_d : man_d;

   fetch_unit dut (
      .clk             (clk),
      .rst_aH          (rst_aH),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .enq_valid       (enq_valid),
      .enq_ready       (enq_ready),
      .enq_data        (enq_data)
`ifdef FETCH_INIT_EN
      ,
      .init            (init),
      .init_pc         (init_pc)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model: answers a handshake one cycle later with {16'h1300, addr[15:0]}.
   initial begin : mem_proc
      logic        hs;
      logic [31:0] a;
      auto_v = 1'b0;
      auto_d = '0;
      forever begin
         @(negedge clk);
         hs = auto_mem && imem_req_valid && imem_req_ready && !rst_aH;
         a  = imem_req_addr;
         @(posedge clk);
         #1;
         auto_v = hs;
         auto_d = hs ? {16'h1300, a[15:0]} : 32'h0;
      end
   end

   // Monitor: pops the scoreboard whenever a request or enqueue handshake is presented.
   always @(negedge clk) begin
      if (!rst_aH) begin
         if (imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) chk("req_unexpected", {32'h0, imem_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("req_addr", {32'h0, imem_req_addr}, {32'h0, exp_req.pop_front()});
         end
         if (enq_valid && enq_ready) begin
            enq_cyc.push_back(cyc);
            if (exp_enq.size() == 0) chk("enq_unexpected", enq_data, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("enq_entry", enq_data, exp_enq.pop_front());
         end
      end
   end

   initial begin
      rst_aH = 1'b1; imem_req_ready = 1'b0; auto_mem = 1'b0;
      man_v = 1'b0; man_d = '0; redirect_valid = 1'b0; redirect_pc = '0; enq_ready = 1'b1;
`ifdef FETCH_INIT_EN
      init = 1'b0; init_pc = '0;
`endif
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", {63'h0, imem_req_valid}, 64'd0);
      chk("rst_enq_valid", {63'h0, enq_valid}, 64'd0);
      chk("rst_enq_data", enq_data, 64'd0);
      @(posedge clk); #1; rst_aH = 1'b0;
      @(negedge clk);
      chk("post_rst_req_valid", {63'h0, imem_req_valid}, 64'd1);
      chk("post_rst_addr", {32'h0, imem_req_addr}, 64'h0);
      @(posedge clk); #1;

      // Back-to-back fetch, FIFO always ready: three entries, 3 cycles apart
      exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
      exp_enq.push_back(64'h0000_0000_1300_0000);
      exp_enq.push_back(64'h0000_0004_1300_0004);
      exp_enq.push_back(64'h0000_0008_1300_0008);
      auto_mem = 1'b1; imem_req_ready = 1'b1;
      repeat (9) tick();
      imem_req_ready = 1'b0;
      @(negedge clk);
      chk("seq_next_addr", {32'h0, imem_req_addr}, 64'hC);
      chk("enq_count", enq_cyc.size(), 64'd3);
      if (enq_cyc.size() >= 3) begin
         chk("enq_spacing_0", enq_cyc[1] - enq_cyc[0], 64'd3);
         chk("enq_spacing_1", enq_cyc[2] - enq_cyc[1], 64'd3);
      end
      @(posedge clk); #1;

      // FIFO full for 5 cycles in HOLD
      exp_req.push_back(32'hC);
      exp_enq.push_back(64'h0000_000C_1300_000C);
      imem_req_ready = 1'b1; enq_ready = 1'b0;
      tick();
      imem_req_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_enq_valid", {63'h0, enq_valid}, 64'd1);
         chk("stall_enq_data", enq_data, 64'h0000_000C_1300_000C);
         @(posedge clk); #1;
      end
      enq_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("stall_next_valid", {63'h0, imem_req_valid}, 64'd1);
      chk("stall_next_addr", {32'h0, imem_req_addr}, 64'h10);
      @(posedge clk); #1;

      // Redirect in WAIT, stale response two cycles later is dropped
      auto_mem = 1'b0; imem_req_ready = 1'b1;
      exp_req.push_back(32'h10);
      tick();
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      tick();
      man_v = 1'b1; man_d = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("drain_req_valid", {63'h0, imem_req_valid}, 64'd0);
      @(posedge clk); #1;
      man_v = 1'b0;
      @(negedge clk);
      chk("redir_wait_valid", {63'h0, imem_req_valid}, 64'd1);
      chk("redir_wait_addr", {32'h0, imem_req_addr}, 64'h100);
      @(posedge clk); #1;

      // Redirect to 0x203 in HOLD with enq_ready high: no enqueue
      auto_mem = 1'b1; imem_req_ready = 1'b1;
      exp_req.push_back(32'h100);
      tick();
      imem_req_ready = 1'b0;
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      @(negedge clk);
      chk("redir_hold_enq_valid", {63'h0, enq_valid}, 64'd0);
      chk("redir_hold_enq_data", enq_data, 64'h0000_0100_1300_0100);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_hold_addr", {32'h0, imem_req_addr}, 64'h200);
      @(posedge clk); #1;

      // Reset while WAIT, stale response afterwards is ignored
      auto_mem = 1'b0; imem_req_ready = 1'b1;
      exp_req.push_back(32'h200);
      tick();
      imem_req_ready = 1'b0; rst_aH = 1'b1;
      #1;
      chk("midrst_req_valid", {63'h0, imem_req_valid}, 64'd0);
      chk("midrst_enq_valid", {63'h0, enq_valid}, 64'd0);
      @(posedge clk); #1; rst_aH = 1'b0;
      @(negedge clk);
      chk("midrst_addr", {32'h0, imem_req_addr}, 64'h0);
      @(posedge clk); #1;
      man_v = 1'b1; man_d = 32'hBAD0_0001;
      tick();
      man_v = 1'b0;
      @(negedge clk);
      chk("stale_enq_valid", {63'h0, enq_valid}, 64'd0);
      chk("stale_req_valid", {63'h0, imem_req_valid}, 64'd1);
      chk("stale_addr", {32'h0, imem_req_addr}, 64'h0);
      @(posedge clk); #1;
      auto_mem = 1'b1; imem_req_ready = 1'b1;
      exp_req.push_back(32'h0);
      exp_enq.push_back(64'h0000_0000_1300_0000);
      tick();
      imem_req_ready = 1'b0;
      tick(); tick();

      // Redirect in REQ to an unaligned top address, then wrap to 0
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("wrap_addr", {32'h0, imem_req_addr}, 64'hFFFF_FFFC);
      @(posedge clk); #1;
      imem_req_ready = 1'b1;
      exp_req.push_back(32'hFFFF_FFFC);
      exp_enq.push_back(64'hFFFF_FFFC_1300_FFFC);
      tick();
      imem_req_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("wrap_next_valid", {63'h0, imem_req_valid}, 64'd1);
      chk("wrap_next_addr", {32'h0, imem_req_addr}, 64'h0);
      @(posedge clk); #1;

`ifdef FETCH_INIT_EN
      // Init preload beats a simultaneous redirect
      init = 1'b1; init_pc = 32'hFFFF_FFFC;
      redirect_valid = 1'b1; redirect_pc = 32'h500;
      tick();
      init = 1'b0; redirect_valid = 1'b0;
      @(negedge clk);
      chk("init_addr", {32'h0, imem_req_addr}, 64'hFFFF_FFFC);
      @(posedge clk); #1;
      imem_req_ready = 1'b1;
      exp_req.push_back(32'hFFFF_FFFC);
      exp_enq.push_back(64'hFFFF_FFFC_1300_FFFC);
      tick();
      imem_req_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("init_wrap_addr", {32'h0, imem_req_addr}, 64'h0);
      @(posedge clk); #1;
`endif

      repeat (3) tick();
      chk("req_queue_empty", exp_req.size(), 64'd0);
      chk("enq_queue_empty", exp_enq.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
